bin2dec_display: RTL
====================

# bin2dec_display

- Sequential binary-to-decimal formatter for the six-digit seven-segment multiplexer.
- Converts an unsigned binary value (SDRAM test counters, error counts, addresses) into six `{dp, char[4:0]}` digit codes with an iterative double-dabble engine.
- Digit outputs drive the multiplexer's `in0`..`in5` inputs directly.
- Outputs hold the last completed result, so the display never shows a partial conversion.

## Interface
- `W`, 20: binary input width; legal range 4..20.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; accepted only while `busy`=0.
- `bin`  in  W  value to convert; sampled on the accepted `start`.
- `dp_mask`  in  6  decimal-point enables; bit i drives bit 5 of `dig`i. Sampled on the accepted `start`.
- `dig0`..`dig5`  out  6 each  `{dp, char}` codes. `dig0` is the units digit and feeds `in0`.
- `busy`  out  1  high while a conversion is in flight.
- `done`  out  1  one-cycle pulse when new digits are presented.
- `ovf`  out  1  high when the displayed result is the overflow pattern; held until the next `done`.

## Operation
- FSM states: IDLE, SHIFT, FORMAT.
- **IDLE, `start`=1:**
  - Latch `bin` into the shift register and `dp_mask`.
  - Clear the 24-bit BCD register and the bit counter.
  - Set the overflow flag if `bin` > 999999 (only possible when W=20).
  - Go to SHIFT.
- **SHIFT, each cycle:**
  - Add 3 to every BCD nibble ≥ 5.
  - Shift `{bcd, bin}` left by 1 and increment the counter.
  - After W shifts, go to FORMAT.
  - BCD bits shifted beyond 24 are discarded; the overflow flag already covers that case.
- **FORMAT, one cycle:**
  - Write `dig0`..`dig5`, pulse `done`, update `ovf`, return to IDLE.
  - Normal result: `dig`i = `{dp_mask[i], 1'b0, nibble i}`.
  - Overflow result: `dig2`=21 (O), `dig1`=15 (F), `dig0`=20 (L), `dig3`..`dig5`=28 (OFF). Decimal points are forced to 0.
- `start` while `busy`=1 is ignored. No queueing, no error flag.
- Char codes 29..31 are never produced.
- Arithmetic:
  - Nibble correction is a 4-bit add with no carry-out; a corrected nibble is ≤ 12 before the shift.
  - The counter is 5 bits wide and compares against W.

## Timing
- **Reset values:**
  - `dig0`..`dig5` = 6'd28 (blank); `busy`=0, `done`=0, `ovf`=0.
  - FSM in IDLE; internal registers cleared.
- **Latency:** `start` accepted at cycle 0 → `busy`=1 from cycle 1 → `done`=1 and new digits valid at cycle W+1 → `busy`=0 from cycle W+2.
- Back-to-back conversions are possible: a `start` in cycle W+2 is accepted. Throughput is one conversion per W+2 cycles.
- **`rst` mid-conversion:** abandons the conversion, blanks all digits, and produces no `done` pulse.
- **Simultaneous `start` and `rst`:** `rst` wins.
- `done` and `busy` are both 1 in the FORMAT cycle.
- `dig` outputs change only in the FORMAT cycle or on reset.

## Configuration
- Macro: `BIN2DEC_LZ_BLANK_EN`.
- **With the macro defined** (applies to normal results only):
  - Digit i (i ≥ 1) is replaced by 28 (OFF) when its nibble and every higher nibble are zero.
  - A digit is never blanked if its own `dp_mask` bit, or any higher `dp_mask` bit, is set.
  - `dig0` is never blanked.
- **Without the macro:** leading zeros are shown as 0.
- The overflow pattern is identical in both builds.

## Structure
- Shared package `disp_pkg` holds:
  - char-code constants: `CH_OFF`=28, `CH_O`=21, `CH_F`=15, `CH_L`=20;
  - `DEC_MAX`=999999;
  - the FSM state enum.
- Sub-module `bcd_add3`: combinational nibble correction (≥5 → +3), instantiated 6 times.
- All sequencing stays in the top module.

## Test plan
- `bin`=123456, `dp_mask`=0 → at cycle 21: `dig5`..`dig0` = 1,2,3,4,5,6; `done` high for exactly one cycle; `ovf`=0.
- `bin`=42, `dp_mask`=6'b000100:
  - with `BIN2DEC_LZ_BLANK_EN`: `dig5`=28, `dig4`=28, `dig3`=28, `dig2`=6'b100000, `dig1`=4, `dig0`=2;
  - without the macro: `dig5`..`dig3` = 0.
- `bin`=1000000 (W=20) → `dig2`=21, `dig1`=15, `dig0`=20, `dig5`..`dig3` = 28, `ovf`=1. A following conversion of `bin`=7 clears `ovf`.
- Convert `bin`=999999, then pulse `start` with `bin`=5 at cycle 10 → the second request is ignored; `done` fires once, with 9,9,9,9,9,9.
- Assert `rst` at cycle 8 of a conversion → all digits 28, no `done`, `busy`=0 next cycle. A new `start` after reset completes normally.
- W=4, `bin`=15 → `done` at cycle 5; `dig1`=1, `dig0`=5.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared definitions for the seven-segment display path: character codes,
// decimal range limit, formatter FSM states and digit-code helpers.
package disp_pkg;

    // Character codes understood by the six-digit multiplexer
    localparam logic [4:0] CH_OFF = 5'd28;
    localparam logic [4:0] CH_O   = 5'd21;
    localparam logic [4:0] CH_F   = 5'd15;
    localparam logic [4:0] CH_L   = 5'd20;

    // Largest value that fits in six decimal digits
    localparam int unsigned DEC_MAX = 999999;

    // Formatter sequencing states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FORMAT = 2'd2
    } state_e;

    // Decimal digit with optional decimal point: {dp, 1'b0, bcd nibble}
    function automatic logic [5:0] mk_dig(input logic dp, input logic [3:0] nib);
        return {dp, 1'b0, nib};
    endfunction

    // Overflow banner "OFL" right-aligned, upper digits dark, no decimal points
    function automatic logic [5:0] ovf_code(input int idx);
        logic [5:0] code;
        case (idx)
            0:       code = {1'b0, CH_L};
            1:       code = {1'b0, CH_F};
            2:       code = {1'b0, CH_O};
            default: code = {1'b0, CH_OFF};
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: a BCD nibble of 5 or more gets 3 added
// before the shift so it carries correctly into the next decade.
module bcd_add3 (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    // 4-bit add, carry-out dropped; legal inputs are 0..9 so the result is at most 12
    always_comb begin
        if (nib_i >= 4'd5) begin
            nib_o = nib_i + 4'd3;
        end else begin
            nib_o = nib_i;
        end
    end

endmodule

// File: rtl/bin2dec_display.sv
// Sequential binary-to-decimal formatter feeding the six-digit seven-segment
// multiplexer. An iterative double-dabble engine converts W bits in W cycles;
// the digit registers are only rewritten when a conversion completes, so the
// display never shows a partial result.
// Optional build macro: BIN2DEC_LZ_BLANK_EN (blank leading zeros).
import disp_pkg::*;

module bin2dec_display #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] bin,
    input  logic [5:0]   dp_mask,
    output logic [5:0]   dig0,
    output logic [5:0]   dig1,
    output logic [5:0]   dig2,
    output logic [5:0]   dig3,
    output logic [5:0]   dig4,
    output logic [5:0]   dig5,
    output logic         busy,
    output logic         done,
    output logic         ovf
);

    localparam logic [4:0] CNT_LAST = 5'(W - 1);

    state_e       state_q, state_d;
    logic [W-1:0] shift_q, shift_d;
    logic [23:0]  bcd_q, bcd_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [5:0]   dp_q, dp_d;
    logic         ovf_pend_q, ovf_pend_d;
    logic         ovf_q, ovf_d;
    logic [5:0]   dig_q [6];
    logic [5:0]   dig_d [6];

    logic [23:0]  bcd_adj;
    logic [23:0]  bcd_shift;
    logic [5:0]   norm_dig [6];
    logic [5:0]   fmt_dig  [6];
    logic         unused_bcd_msb;

    // Per-decade correction ahead of each shift
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_add3
            bcd_add3 u_add3 (
                .nib_i (bcd_q[gi*4 +: 4]),
                .nib_o (bcd_adj[gi*4 +: 4])
            );
        end
    endgenerate

    // Next BCD value: corrected digits shifted up with the next binary bit;
    // anything pushed past the sixth decade is lost, which the overflow
    // flag captured at start already accounts for.
    assign bcd_shift      = {bcd_adj[22:0], shift_q[W-1]};
    assign unused_bcd_msb = bcd_adj[23];

`ifdef BIN2DEC_LZ_BLANK_EN
    logic [5:0] keep;

    // A digit stays lit if it or any higher digit is non-zero or carries a
    // decimal point; the units digit is always lit.
    always_comb begin
        logic run;
        run  = 1'b0;
        keep = '0;
        for (int i = 5; i >= 0; i--) begin
            run     = run | (bcd_shift[i*4 +: 4] != 4'd0) | dp_q[i];
            keep[i] = run;
        end
        keep[0] = 1'b1;
    end

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_norm
            assign norm_dig[gi] = keep[gi] ? mk_dig(dp_q[gi], bcd_shift[gi*4 +: 4])
                                           : {1'b0, CH_OFF};
        end
    endgenerate
`else
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_norm
            assign norm_dig[gi] = mk_dig(dp_q[gi], bcd_shift[gi*4 +: 4]);
        end
    endgenerate
`endif

    // Final digit codes: overflow banner takes precedence over the decimal result
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_fmt
            assign fmt_dig[gi] = ovf_pend_q ? ovf_code(gi) : norm_dig[gi];
        end
    endgenerate

    // Sequencing: accept a request, run W shift cycles, present the result
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        dp_d       = dp_q;
        ovf_pend_d = ovf_pend_q;
        ovf_d      = ovf_q;
        for (int i = 0; i < 6; i++) begin
            dig_d[i] = dig_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shift_d    = bin;
                    dp_d       = dp_mask;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    ovf_pend_d = (32'(bin) > DEC_MAX);
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bcd_d   = bcd_shift;
                shift_d = shift_q << 1;
                cnt_d   = cnt_q + 5'd1;
                // The last shift loads the display registers so the new
                // digits are already stable throughout the FORMAT cycle.
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FORMAT;
                    ovf_d   = ovf_pend_q;
                    for (int i = 0; i < 6; i++) begin
                        dig_d[i] = fmt_dig[i];
                    end
                end
            end
            ST_FORMAT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset blanks the display and abandons any conversion
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            dp_q       <= '0;
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                dig_q[i] <= {1'b0, CH_OFF};
            end
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            dp_q       <= dp_d;
            ovf_pend_q <= ovf_pend_d;
            ovf_q      <= ovf_d;
            for (int i = 0; i < 6; i++) begin
                dig_q[i] <= dig_d[i];
            end
        end
    end

    assign dig0 = dig_q[0];
    assign dig1 = dig_q[1];
    assign dig2 = dig_q[2];
    assign dig3 = dig_q[3];
    assign dig4 = dig_q[4];
    assign dig5 = dig_q[5];
    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_FORMAT);
    assign ovf  = ovf_q;

endmodule
